mmio_regmem_slave: RTL and testbench

- Parametrised MMIO slave for CCI-P AFUs: DFH/AFU_ID header, NUM_REGS 64-bit user registers, a status/counter register, and a single-port-write/single-port-read block RAM window.
- Every read, register or memory, answers with one fixed latency RD_LATENCY, so host reads pipeline back-to-back.
- Sits between the AFU's registered CCI-P c0 MMIO request fields and the c2 MMIO response channel.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_rsp_pipe.sv | 50 +++++
 rtl/mmio_regmem_slave.sv | 159 +++++++++++++++
 tb/tb_mmio_regmem_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - MMIO address map, header constants, region tags and response type
package mmio_pkg;

  localparam logic [15:0] ADDR_DFH           = 16'h0000;
  localparam logic [15:0] ADDR_AFU_ID_L      = 16'h0002;
  localparam logic [15:0] ADDR_AFU_ID_H      = 16'h0004;
  localparam logic [15:0] ADDR_RSVD0         = 16'h0006;
  localparam logic [15:0] ADDR_RSVD1         = 16'h0008;
  localparam logic [15:0] ADDR_STATUS        = 16'h000A;
  localparam logic [15:0] ADDR_USER_REG_BASE = 16'h0020;

  localparam logic [3:0]  DFH_FEATURE_TYPE = 4'b0001;
  localparam logic        DFH_EOL          = 1'b1;
  localparam logic [63:0] DFH_VALUE = {DFH_FEATURE_TYPE, 8'b0, 4'b0, 7'b0, DFH_EOL, 24'b0, 4'b0, 12'b0};

  typedef enum logic [2:0] {
    RGN_HDR,
    RGN_STATUS,
    RGN_USER,
    RGN_MEM,
    RGN_UNMAPPED
  } t_mmio_region;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_mmio_rsp;

endpackage

// File: rtl/mmio_rsp_pipe.sv
// rtl/mmio_rsp_pipe.sv - fixed-depth delay line carrying read valid, tid, region tag and register data
module mmio_rsp_pipe
  import mmio_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [8:0]   i_tid,
  input  t_mmio_region i_region,
  input  logic [63:0]  i_data,
  output logic         o_valid,
  output logic [8:0]   o_tid,
  output t_mmio_region o_region,
  output logic [63:0]  o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [8:0]       r_tid    [DEPTH];
  t_mmio_region     r_region [DEPTH];
  logic [63:0]      r_data   [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int k = 1; k < DEPTH; k++) r_valid[k] <= r_valid[k-1];
    end
  end

  // Payload only matters while its valid bit is set, so it carries no reset.
  always_ff @(posedge i_clk) begin
    r_tid[0]    <= i_tid;
    r_region[0] <= i_region;
    r_data[0]   <= i_data;
    for (int k = 1; k < DEPTH; k++) begin
      r_tid[k]    <= r_tid[k-1];
      r_region[k] <= r_region[k-1];
      r_data[k]   <= r_data[k-1];
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_tid    = r_tid[DEPTH-1];
  assign o_region = r_region[DEPTH-1];
  assign o_data   = r_data[DEPTH-1];

endmodule

// File: rtl/mmio_regmem_slave.sv
// rtl/mmio_regmem_slave.sv - CCI-P MMIO slave: DFH/AFU_ID header, user registers, status counters, BRAM window
module mmio_regmem_slave
  import mmio_pkg::*;
#(
  parameter int           NUM_REGS       = 4,
  parameter int           MEM_ADDR_WIDTH = 9,
  parameter logic [15:0]  MEM_BASE       = 16'h0030,
  parameter int           RD_LATENCY     = 3,
  parameter logic [127:0] AFU_ID         = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mmio_rd_valid,
  input  logic                    mmio_wr_valid,
  input  logic [15:0]             mmio_addr,
  input  logic [8:0]              mmio_tid,
  input  logic [63:0]             mmio_wr_data,
  output logic                    rsp_valid,
  output logic [8:0]              rsp_tid,
  output logic [63:0]             rsp_data,
  output logic [64*NUM_REGS-1:0]  user_regs
);

  localparam int          MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int          UIDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [16:0] MEM_END   = 17'(MEM_BASE) + 17'(2 * MEM_DEPTH);
  localparam logic [15:0] USER_END  = ADDR_USER_REG_BASE + 16'(2 * NUM_REGS);

  logic [63:0] r_user      [NUM_REGS];
  logic [31:0] r_rd_count;
  logic [31:0] r_bad_count;
  logic [63:0] r_mem       [MEM_DEPTH];
  logic [63:0] r_mem_q;
  logic [63:0] r_mem_dly   [RD_LATENCY-1];
  t_mmio_rsp   r_rsp;

  t_mmio_region              w_region;
  logic [63:0]               w_reg_data;
  logic                      w_in_user;
  logic                      w_in_mem;
  logic                      w_clr;
  logic                      w_bad;
  logic [1:0]                w_bad_inc;
  logic [32:0]               w_bad_sum;
  logic [UIDX_W-1:0]         w_user_idx;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_idx;
  logic                      w_p_valid;
  logic [8:0]                w_p_tid;
  t_mmio_region              w_p_region;
  logic [63:0]               w_p_data;

  // Range checks happen before any subtraction so low addresses never wrap into an index.
  assign w_in_user  = !mmio_addr[0] && (mmio_addr >= ADDR_USER_REG_BASE) && (mmio_addr < USER_END);
  assign w_in_mem   = !mmio_addr[0] && (mmio_addr >= MEM_BASE) && ({1'b0, mmio_addr} < MEM_END);
  assign w_user_idx = UIDX_W'((mmio_addr - ADDR_USER_REG_BASE) >> 1);
  assign w_mem_idx  = MEM_ADDR_WIDTH'((mmio_addr - MEM_BASE) >> 1);

  always_comb begin
    w_region   = RGN_UNMAPPED;
    w_reg_data = '0;
    case (mmio_addr)
      ADDR_DFH:      begin w_region = RGN_HDR; w_reg_data = DFH_VALUE;      end
      ADDR_AFU_ID_L: begin w_region = RGN_HDR; w_reg_data = AFU_ID[63:0];   end
      ADDR_AFU_ID_H: begin w_region = RGN_HDR; w_reg_data = AFU_ID[127:64]; end
      ADDR_RSVD0, ADDR_RSVD1: w_region = RGN_HDR;
      // The STATUS read reports a read count that already includes itself.
      ADDR_STATUS: begin
        w_region   = RGN_STATUS;
        w_reg_data = {r_rd_count + 32'd1, r_bad_count};
      end
      default: begin
        if (w_in_user) begin
          w_region   = RGN_USER;
          w_reg_data = r_user[w_user_idx];
        end else if (w_in_mem) begin
          w_region = RGN_MEM;
        end
      end
    endcase
  end

  assign w_clr     = mmio_wr_valid && (mmio_addr == ADDR_STATUS);
  assign w_bad     = (w_region == RGN_UNMAPPED);
  assign w_bad_inc = {1'b0, mmio_rd_valid & w_bad} + {1'b0, mmio_wr_valid & w_bad};
  assign w_bad_sum = {1'b0, r_bad_count} + 33'(w_bad_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count  <= '0;
      r_bad_count <= '0;
    end else if (w_clr) begin
      r_rd_count  <= '0;
      r_bad_count <= '0;
    end else begin
      if (mmio_rd_valid) r_rd_count <= r_rd_count + 32'd1;
      r_bad_count <= w_bad_sum[32] ? '1 : w_bad_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_user[k] <= '0;
    end else if (mmio_wr_valid && (w_region == RGN_USER)) begin
      r_user[w_user_idx] <= mmio_wr_data;
    end
  end

  always_comb begin
    user_regs = '0;
    for (int k = 0; k < NUM_REGS; k++) user_regs[64*k +: 64] = r_user[k];
  end

  // Read-during-write on the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (mmio_wr_valid && (w_region == RGN_MEM)) r_mem[w_mem_idx] <= mmio_wr_data;
    r_mem_q <= r_mem[w_mem_idx];
  end

  always_ff @(posedge clk) begin
    r_mem_dly[0] <= r_mem_q;
    for (int k = 1; k < RD_LATENCY - 1; k++) r_mem_dly[k] <= r_mem_dly[k-1];
  end

  mmio_rsp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rsp_pipe (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (mmio_rd_valid),
    .i_tid    (mmio_tid),
    .i_region (w_region),
    .i_data   (w_reg_data),
    .o_valid  (w_p_valid),
    .o_tid    (w_p_tid),
    .o_region (w_p_region),
    .o_data   (w_p_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= w_p_valid;
      if (w_p_valid) begin
        r_rsp.tid <= w_p_tid;
        case (w_p_region)
          RGN_MEM:      r_rsp.data <= r_mem_dly[RD_LATENCY-2];
          RGN_UNMAPPED: r_rsp.data <= '0;
          default:      r_rsp.data <= w_p_data;
        endcase
      end
    end
  end

  assign rsp_valid = r_rsp.valid;
  assign rsp_tid   = r_rsp.tid;
  assign rsp_data  = r_rsp.data;

endmodule

// File: tb/tb_mmio_regmem_slave.sv
// tb/tb_mmio_regmem_slave.sv - scoreboard bench driving three slaves (latency 2, 3, 5) with one stimulus stream
module tb_mmio_regmem_slave;

  localparam logic [127:0] AFU     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DFH_EXP = 64'h1000_0100_0000_0000;
  localparam logic [63:0]  AFU_L   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0]  AFU_H   = 64'h0123_4567_89AB_CDEF;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_v = 1'b0;
  logic        wr_v = 1'b0;
  logic [15:0] addr = '0;
  logic [8:0]  tid = '0;
  logic [63:0] wdata = '0;

  logic        rv   [3];
  logic [8:0]  rt   [3];
  logic [63:0] rdat [3];
  logic [255:0] ur  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mmio_regmem_slave #(
      .NUM_REGS       (4),
      .MEM_ADDR_WIDTH (9),
      .MEM_BASE       (16'h0030),
      .RD_LATENCY     (lat_of(g)),
      .AFU_ID         (AFU)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mmio_rd_valid (rd_v),
      .mmio_wr_valid (wr_v),
      .mmio_addr     (addr),
      .mmio_tid      (tid),
      .mmio_wr_data  (wdata),
      .rsp_valid     (rv[g]),
      .rsp_tid       (rt[g]),
      .rsp_data      (rdat[g]),
      .user_regs     (ur[g])
    );
  end

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t sb [$];
  int   head [3] = '{0, 0, 0};
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   track = 1'b1;
  exp_t m_e;

  logic [15:0] tab_a [16];
  logic [63:0] tab_d [16];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d (lat %0d): got %h expected %h", name, k, lat_of(k), act, exp);
    end
  endfunction

  // Each DUT consumes the shared expected stream at its own head index.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        if (head[k] >= sb.size()) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got tid %0d data %h, expected no response", k, rt[k], rdat[k]);
        end else begin
          m_e = sb[head[k]];
          head[k]++;
          chk("rsp_tid", k, 64'(rt[k]), 64'(m_e.tid));
          chk("rsp_data", k, rdat[k], m_e.data);
          chk("rsp_cycle", k, 64'(cyc), 64'(m_e.acc + lat_of(k)));
        end
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [8:0] t,
                       input logic [63:0] wd, input logic [63:0] ex);
    exp_t e;
    @(negedge clk);
    rd_v = r; wr_v = w; addr = a; tid = t; wdata = wd;
    if (r && track) begin
      e.tid = t; e.data = ex; e.acc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_v = 1'b0; wr_v = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rsp_valid", k, 64'(rv[k]), 64'd0);
      chk("reset_rsp_tid", k, 64'(rt[k]), 64'd0);
      chk("reset_rsp_data", k, rdat[k], 64'd0);
      chk("reset_user_regs", k, ur[k][63:0] | ur[k][127:64] | ur[k][191:128] | ur[k][255:192], 64'd0);
    end
    rst_n = 1'b1;

    issue(1, 0, 16'h0000, 9'd1, '0, DFH_EXP);
    issue(1, 0, 16'h0002, 9'd2, '0, AFU_L);
    issue(1, 0, 16'h0004, 9'd3, '0, AFU_H);

    issue(0, 1, 16'h0026, 9'd0, 64'hDEAD_BEEF, '0);
    issue(0, 1, 16'h042E, 9'd0, 64'h55AA, '0);
    issue(1, 0, 16'h0026, 9'd4, '0, 64'hDEAD_BEEF);
    issue(1, 0, 16'h042E, 9'd5, '0, 64'h55AA);
    issue(1, 0, 16'h0430, 9'd6, '0, 64'h0);
    issue(1, 0, 16'h000A, 9'd7, '0, {32'd7, 32'd1});
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk("user_reg3", k, ur[k][255:192], 64'hDEAD_BEEF);
      chk("user_reg0", k, ur[k][63:0], 64'h0);
    end

    issue(0, 1, 16'h0002, 9'd0, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    issue(1, 0, 16'h0002, 9'd30, '0, AFU_L);
    issue(0, 1, 16'h003A, 9'd0, 64'h11, '0);
    issue(1, 1, 16'h003A, 9'd8, 64'h22, 64'h11);
    issue(1, 0, 16'h003A, 9'd9, '0, 64'h22);

    issue(0, 1, 16'h000A, 9'd0, '0, '0);
    issue(1, 0, 16'h0003, 9'd10, '0, 64'h0);
    issue(1, 0, 16'h0003, 9'd11, '0, 64'h0);
    issue(1, 0, 16'h0003, 9'd12, '0, 64'h0);
    issue(1, 0, 16'h000A, 9'd13, '0, {32'd4, 32'd3});
    issue(0, 1, 16'h000A, 9'd0, '0, '0);
    issue(1, 0, 16'h000A, 9'd14, '0, {32'd1, 32'd0});
    issue(1, 1, 16'h000A, 9'd15, '0, {32'd2, 32'd0});
    issue(1, 0, 16'h000A, 9'd16, '0, {32'd1, 32'd0});
    idle(8);

    track = 1'b0;
    issue(1, 0, 16'h0000, 9'd20, '0, '0);
    issue(1, 0, 16'h0002, 9'd21, '0, '0);
    @(negedge clk);
    rd_v = 1'b0; wr_v = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    track = 1'b1;
    for (int k = 0; k < 3; k++)
      chk("midreset_user_regs", k, ur[k][63:0] | ur[k][127:64] | ur[k][191:128] | ur[k][255:192], 64'd0);
    idle(6);
    issue(1, 0, 16'h000A, 9'd22, '0, {32'd1, 32'd0});
    issue(1, 0, 16'h042E, 9'd23, '0, 64'h55AA);

    issue(0, 1, 16'h0020, 9'd0, 64'h1111_2222_3333_4444, '0);
    issue(0, 1, 16'h0022, 9'd0, 64'h5555_6666_7777_8888, '0);
    issue(0, 1, 16'h0024, 9'd0, 64'h9999_AAAA_BBBB_CCCC, '0);
    issue(0, 1, 16'h0026, 9'd0, 64'hDDDD_EEEE_FFFF_0000, '0);
    issue(0, 1, 16'h0030, 9'd0, 64'hCAFE_0000_0000_0000, '0);
    issue(0, 1, 16'h0032, 9'd0, 64'hCAFE_0000_0000_0001, '0);
    issue(0, 1, 16'h0034, 9'd0, 64'h0123_0000_0000_0002, '0);
    issue(0, 1, 16'h0036, 9'd0, 64'hFFFF_FFFF_FFFF_FFFF, '0);

    tab_a[0]  = 16'h0000; tab_d[0]  = DFH_EXP;
    tab_a[1]  = 16'h0002; tab_d[1]  = AFU_L;
    tab_a[2]  = 16'h0004; tab_d[2]  = AFU_H;
    tab_a[3]  = 16'h0006; tab_d[3]  = 64'h0;
    tab_a[4]  = 16'h0020; tab_d[4]  = 64'h1111_2222_3333_4444;
    tab_a[5]  = 16'h0022; tab_d[5]  = 64'h5555_6666_7777_8888;
    tab_a[6]  = 16'h0024; tab_d[6]  = 64'h9999_AAAA_BBBB_CCCC;
    tab_a[7]  = 16'h0026; tab_d[7]  = 64'hDDDD_EEEE_FFFF_0000;
    tab_a[8]  = 16'h0030; tab_d[8]  = 64'hCAFE_0000_0000_0000;
    tab_a[9]  = 16'h0032; tab_d[9]  = 64'hCAFE_0000_0000_0001;
    tab_a[10] = 16'h0034; tab_d[10] = 64'h0123_0000_0000_0002;
    tab_a[11] = 16'h0036; tab_d[11] = 64'hFFFF_FFFF_FFFF_FFFF;
    tab_a[12] = 16'h003A; tab_d[12] = 64'h22;
    tab_a[13] = 16'h042E; tab_d[13] = 64'h55AA;
    tab_a[14] = 16'h0031; tab_d[14] = 64'h0;
    tab_a[15] = 16'h0430; tab_d[15] = 64'h0;
    for (int i = 0; i < 64; i++) begin
      int j;
      j = int'($urandom_range(15, 0));
      issue(1, 0, tab_a[j], 9'(100 + i), '0, tab_d[j]);
    end
    idle(12);

    for (int k = 0; k < 3; k++) chk("rsp_count", k, 64'(head[k]), 64'(sb.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
